// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package cu_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALTED = 3'd5
   } state_t;

   // Decoded instruction kind; K_ILL retires like a NOP but flags illegal.
   typedef enum logic [3:0] {
      K_ALU  = 4'd0,
      K_LDI  = 4'd1,
      K_MOV  = 4'd2,
      K_LD   = 4'd3,
      K_ST   = 4'd4,
      K_BR   = 4'd5,
      K_NOP  = 4'd6,
      K_HALT = 4'd7,
      K_ILL  = 4'd8
   } kind_t;

   // Instruction class in op[5:4].
   localparam logic [1:0] CLS_ALU = 2'b00;
   localparam logic [1:0] CLS_LS  = 2'b01;
   localparam logic [1:0] CLS_BR  = 2'b10;
   localparam logic [1:0] CLS_SYS = 2'b11;

   // Load/store class sub-codes in op[3:0].
   localparam logic [3:0] SUB_LDI = 4'b0001;
   localparam logic [3:0] SUB_MOV = 4'b0010;
   localparam logic [3:0] SUB_LD  = 4'b0100;
   localparam logic [3:0] SUB_ST  = 4'b1000;

   // Branch conditions in op[3:0]; anything else never branches.
   localparam logic [3:0] COND_ALWAYS = 4'b0000;
   localparam logic [3:0] COND_ZS     = 4'b0001;
   localparam logic [3:0] COND_ZC     = 4'b0010;
   localparam logic [3:0] COND_CS     = 4'b0011;
   localparam logic [3:0] COND_CC     = 4'b0100;

   // Status register bit positions, {V,N,Z,C}.
   localparam int SREG_C = 0;
   localparam int SREG_Z = 1;
   localparam int SREG_N = 2;
   localparam int SREG_V = 3;

   // System opcodes.
   localparam logic [5:0] OP_NOP  = 6'b110000;
   localparam logic [5:0] OP_HALT = 6'b110001;

   // Map a 6-bit opcode to the instruction kind that drives sequencing.
   function automatic kind_t decode_kind(input logic [5:0] op);
      kind_t k;
      k = K_ILL;
      case (op[5:4])
         CLS_ALU: k = K_ALU;
         CLS_LS: begin
            case (op[3:0])
               SUB_LDI: k = K_LDI;
               SUB_MOV: k = K_MOV;
               SUB_LD:  k = K_LD;
               SUB_ST:  k = K_ST;
               default: k = K_ILL;
            endcase
         end
         CLS_BR: k = K_BR;
         default: begin
            if (op == OP_NOP)
               k = K_NOP;
            else if (op == OP_HALT)
               k = K_HALT;
            else
               k = K_ILL;
         end
      endcase
      return k;
   endfunction

endpackage

// File: rtl/cu_branch_eval.sv
// Branch condition evaluation against the current Z and C flags.
module cu_branch_eval
   import cu_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic       i_z,
   input  logic       i_c,
   output logic       o_taken,
   output logic       o_illegal
);

   // Undefined conditions never branch and are reported as illegal.
   always_comb begin
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      case (i_cond)
         COND_ALWAYS: o_taken = 1'b1;
         COND_ZS:     o_taken = i_z;
         COND_ZC:     o_taken = ~i_z;
         COND_CS:     o_taken = i_c;
         COND_CC:     o_taken = ~i_c;
         default:     o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/write-back
// for the 8-bit core, owns the PC and the status register.
//
// state     | meaning
// ----------+------------------------------------------------------------
// FETCH     | latch instruction at pc into IR
// DECODE    | present register read addresses; branch/NOP/HALT retire here
// EXEC      | capture register operands and data-memory address/data
// MEM       | data-memory read (LD) or write (ST); ST retires here
// WB        | register-file write; ALU also updates SREG
// HALTED    | frozen until reset
module multicycle_cu
   import cu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8,
   parameter int REG_AW = 3,
   parameter int DM_AW  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr_i,
   output logic [PC_W-1:0]   pc_o,
   output logic [REG_AW-1:0] rf_ra_o,
   output logic [REG_AW-1:0] rf_rb_o,
   input  logic [DATA_W-1:0] rf_rda_i,
   input  logic [DATA_W-1:0] rf_rdb_i,
   output logic              rf_we_o,
   output logic [REG_AW-1:0] rf_wa_o,
   output logic [DATA_W-1:0] rf_wd_o,
   output logic [DATA_W-1:0] rf_wd_hi_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [3:0]        alu_fsl_o,
   input  logic [DATA_W-1:0] alu_lo_i,
   input  logic [DATA_W-1:0] alu_hi_i,
   input  logic [3:0]        alu_flags_i,
   output logic [DM_AW-1:0]  dm_addr_o,
   output logic [DATA_W-1:0] dm_wd_o,
   output logic              dm_re_o,
   output logic              dm_we_o,
   input  logic [DATA_W-1:0] dm_rd_i,
   output logic [3:0]        sreg_o,
   output logic              halted_o,
   output logic              done_o,
   output logic              illegal_o
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [15:0]         r_ir;
   logic [PC_W-1:0]     r_pc;
   logic [3:0]          r_sreg;
   logic [DATA_W-1:0]   r_opa;
   logic [DATA_W-1:0]   r_opb;
   logic [DM_AW-1:0]    r_dm_addr;
   logic [DATA_W-1:0]   r_dm_wd;

   logic [5:0]          w_op;
   kind_t               w_kind;
   logic                w_is_alu_cls;
   logic [DATA_W-1:0]   w_imm;
   logic                w_br_taken;
   logic                w_br_ill;
   logic                w_done;
   logic                w_illegal;
   logic                w_rf_we;
   logic                w_dm_re;
   logic                w_dm_we;

   assign w_op         = r_ir[15:10];
   assign w_kind       = decode_kind(w_op);
   assign w_is_alu_cls = (w_op[5:4] == CLS_ALU);
   assign w_imm        = DATA_W'(r_ir[9:3]);

   cu_branch_eval u_branch (
      .i_cond    (w_op[3:0]),
      .i_z       (r_sreg[SREG_Z]),
      .i_c       (r_sreg[SREG_C]),
      .o_taken   (w_br_taken),
      .o_illegal (w_br_ill)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_FETCH;
      else
         r_state <= w_state_nxt;
   end

   // Next-state selection; each instruction kind takes its own path.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FETCH: w_state_nxt = ST_DECODE;
         ST_DECODE: begin
            case (w_kind)
               K_ALU, K_MOV, K_LD, K_ST: w_state_nxt = ST_EXEC;
               K_LDI:                    w_state_nxt = ST_WB;
               K_HALT:                   w_state_nxt = ST_HALTED;
               default:                  w_state_nxt = ST_FETCH;
            endcase
         end
         ST_EXEC: begin
            if (w_kind == K_LD || w_kind == K_ST)
               w_state_nxt = ST_MEM;
            else
               w_state_nxt = ST_WB;
         end
         ST_MEM: begin
            if (w_kind == K_LD)
               w_state_nxt = ST_WB;
            else
               w_state_nxt = ST_FETCH;
         end
         ST_WB:     w_state_nxt = ST_FETCH;
         ST_HALTED: w_state_nxt = ST_HALTED;
         default:   w_state_nxt = ST_FETCH;
      endcase
   end

   // Strobes and retire pulses from state; reset squashes them so an
   // aborted WB/MEM cycle never writes.
   always_comb begin
      w_rf_we   = 1'b0;
      w_dm_re   = 1'b0;
      w_dm_we   = 1'b0;
      w_done    = 1'b0;
      w_illegal = 1'b0;
      case (r_state)
         ST_DECODE: begin
            if (w_kind == K_BR || w_kind == K_NOP ||
                w_kind == K_HALT || w_kind == K_ILL) begin
               w_done    = 1'b1;
               w_illegal = (w_kind == K_ILL) || (w_kind == K_BR && w_br_ill);
            end
         end
         ST_MEM: begin
            w_dm_re = (w_kind == K_LD);
            w_dm_we = (w_kind == K_ST);
            w_done  = (w_kind == K_ST);
         end
         ST_WB: begin
            w_rf_we = 1'b1;
            w_done  = 1'b1;
         end
         default: ;
      endcase
      if (rst) begin
         w_rf_we   = 1'b0;
         w_dm_re   = 1'b0;
         w_dm_we   = 1'b0;
         w_done    = 1'b0;
         w_illegal = 1'b0;
      end
   end

   // Instruction register and EXEC-stage operand capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir      <= '0;
         r_opa     <= '0;
         r_opb     <= '0;
         r_dm_addr <= '0;
         r_dm_wd   <= '0;
      end else begin
         if (r_state == ST_FETCH)
            r_ir <= instr_i;
         if (r_state == ST_EXEC) begin
            r_opa     <= rf_rda_i;
            r_opb     <= rf_rdb_i;
            r_dm_addr <= rf_rdb_i[DM_AW-1:0];
            r_dm_wd   <= rf_rda_i;
         end
      end
   end

   // PC advances on each retire (HALT holds it); SREG loads on ALU write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc   <= '0;
         r_sreg <= '0;
      end else begin
         if (r_state == ST_WB && w_kind == K_ALU)
            r_sreg <= alu_flags_i;
         if (w_done && w_kind != K_HALT) begin
            if (w_kind == K_BR && w_br_taken)
               r_pc <= r_ir[PC_W-1:0];
            else
               r_pc <= r_pc + PC_W'(1);
         end
      end
   end

   // Register-file address and write-data steering by instruction kind.
   always_comb begin
      rf_ra_o    = REG_AW'(r_ir[6:4]);
      rf_rb_o    = REG_AW'(r_ir[9:7]);
      rf_wa_o    = '0;
      rf_wd_o    = '0;
      rf_wd_hi_o = '0;
      if (w_is_alu_cls) begin
         rf_ra_o = REG_AW'(r_ir[9:7]);
         rf_rb_o = REG_AW'(r_ir[6:4]);
      end
      case (w_kind)
         K_ALU: begin
            rf_wa_o    = REG_AW'(r_ir[3:1]);
            rf_wd_o    = alu_lo_i;
            rf_wd_hi_o = alu_hi_i;
         end
         K_LDI: begin
            rf_wa_o = REG_AW'(r_ir[2:0]);
            rf_wd_o = w_imm;
         end
         K_MOV: begin
            rf_wa_o = REG_AW'(r_ir[9:7]);
            rf_wd_o = r_opa;
         end
         K_LD: begin
            rf_wa_o = REG_AW'(r_ir[6:4]);
            rf_wd_o = dm_rd_i;
         end
         default: ;
      endcase
   end

   assign pc_o      = r_pc;
   assign sreg_o    = r_sreg;
   assign halted_o  = (r_state == ST_HALTED);
   assign done_o    = w_done;
   assign illegal_o = w_illegal;
   assign rf_we_o   = w_rf_we;
   assign dm_re_o   = w_dm_re;
   assign dm_we_o   = w_dm_we;
   assign dm_addr_o = r_dm_addr;
   assign dm_wd_o   = r_dm_wd;
   assign alu_a_o   = r_opa;
   assign alu_b_o   = r_opb;
   assign alu_fsl_o = w_is_alu_cls ? w_op[3:0] : 4'd0;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu with behavioural memories, register file and ALU.
module tb_multicycle_cu;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr_i;
   logic [7:0]  pc_o;
   logic [2:0]  rf_ra_o, rf_rb_o, rf_wa_o;
   logic [7:0]  rf_rda_i, rf_rdb_i, rf_wd_o, rf_wd_hi_o;
   logic        rf_we_o;
   logic [7:0]  alu_a_o, alu_b_o, alu_lo_i, alu_hi_i;
   logic [3:0]  alu_fsl_o, alu_flags_i;
   logic [2:0]  dm_addr_o;
   logic [7:0]  dm_wd_o, dm_rd_i;
   logic        dm_re_o, dm_we_o;
   logic [3:0]  sreg_o;
   logic        halted_o, done_o, illegal_o;

   always #5 clk = ~clk;

   multicycle_cu dut (
      .clk(clk), .rst(rst), .instr_i(instr_i), .pc_o(pc_o),
      .rf_ra_o(rf_ra_o), .rf_rb_o(rf_rb_o), .rf_rda_i(rf_rda_i), .rf_rdb_i(rf_rdb_i),
      .rf_we_o(rf_we_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o), .rf_wd_hi_o(rf_wd_hi_o),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_fsl_o(alu_fsl_o),
      .alu_lo_i(alu_lo_i), .alu_hi_i(alu_hi_i), .alu_flags_i(alu_flags_i),
      .dm_addr_o(dm_addr_o), .dm_wd_o(dm_wd_o), .dm_re_o(dm_re_o), .dm_we_o(dm_we_o),
      .dm_rd_i(dm_rd_i), .sreg_o(sreg_o), .halted_o(halted_o), .done_o(done_o),
      .illegal_o(illegal_o)
   );

   // Environment models.
   logic [15:0] imem [256];
   logic [7:0]  rf   [8];
   logic [7:0]  dmem [8];
   logic        pre_we = 1'b0;
   logic [2:0]  pre_a  = 3'd0;
   logic [7:0]  pre_d  = 8'd0;
   logic [8:0]  alu_sum;

   assign instr_i = imem[pc_o];

   always @(posedge clk) begin
      rf_rda_i <= rf[rf_ra_o];
      rf_rdb_i <= rf[rf_rb_o];
      if (pre_we)
         rf[pre_a] <= pre_d;
      else if (rf_we_o)
         rf[rf_wa_o] <= rf_wd_o;
      if (dm_we_o)
         dmem[dm_addr_o] <= dm_wd_o;
      if (dm_re_o)
         dm_rd_i <= dmem[dm_addr_o];
   end

   // fsl 0 = add, anything else = and.
   always_comb begin
      alu_sum = 9'd0;
      if (alu_fsl_o == 4'd0) begin
         alu_sum  = {1'b0, alu_a_o} + {1'b0, alu_b_o};
         alu_lo_i = alu_sum[7:0];
         alu_hi_i = {7'd0, alu_sum[8]};
         alu_flags_i = {(alu_a_o[7] == alu_b_o[7]) && (alu_sum[7] != alu_a_o[7]),
                        alu_sum[7], (alu_sum[7:0] == 8'd0), alu_sum[8]};
      end else begin
         alu_lo_i = alu_a_o & alu_b_o;
         alu_hi_i = 8'd0;
         alu_flags_i = {1'b0, alu_lo_i[7], (alu_lo_i == 8'd0), 1'b0};
      end
   end

   // Scoreboard.
   typedef struct {
      int         kind;      // 0 rf write, 1 dm write, 2 retire
      logic [2:0] wa;
      logic [7:0] wd;
      logic [7:0] wd_hi;
      bit         chk_hi;
      logic [2:0] addr;
      logic [7:0] pc;
      int         lat;
      bit         ill;
      bit         dmre;
      logic [3:0] sreg;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic e_rfw(input logic [2:0] wa, input logic [7:0] wd, input logic [7:0] hi, input bit ch);
      exp_t e;
      e.kind = 0; e.wa = wa; e.wd = wd; e.wd_hi = hi; e.chk_hi = ch;
      sbq.push_back(e);
   endtask

   task automatic e_dmw(input logic [2:0] addr, input logic [7:0] wd);
      exp_t e;
      e.kind = 1; e.addr = addr; e.wd = wd;
      sbq.push_back(e);
   endtask

   task automatic e_ret(input logic [7:0] pc, input int lat, input bit ill, input bit dmre, input logic [3:0] sreg);
      exp_t e;
      e.kind = 2; e.pc = pc; e.lat = lat; e.ill = ill; e.dmre = dmre; e.sreg = sreg;
      sbq.push_back(e);
   endtask

   task automatic take(input int kind, output bit ok, output exp_t e);
      ok = 1'b0;
      n_cmp++;
      if (sbq.size() == 0) begin
         n_bad++;
         $display("FAIL sb_event: got event kind %0d expected no event", kind);
      end else begin
         e = sbq.pop_front();
         if (e.kind != kind) begin
            n_bad++;
            $display("FAIL sb_order: got event kind %0d expected kind %0d", kind, e.kind);
         end else
            ok = 1'b1;
      end
   endtask

   int   cyc = 0;
   bit   seen_re = 1'b0;
   exp_t m_e;
   bit   m_ok;

   // Monitor: compare every DUT event against the queued expectation.
   always @(negedge clk) begin
      if (rst) begin
         cyc = 0;
         seen_re = 1'b0;
      end else begin
         cyc++;
         if (dm_re_o) seen_re = 1'b1;
         if (rf_we_o) begin
            take(0, m_ok, m_e);
            if (m_ok) begin
               chk("rf_wa", rf_wa_o, m_e.wa);
               chk("rf_wd", rf_wd_o, m_e.wd);
               if (m_e.chk_hi) chk("rf_wd_hi", rf_wd_hi_o, m_e.wd_hi);
            end
         end
         if (dm_we_o) begin
            take(1, m_ok, m_e);
            if (m_ok) begin
               chk("dm_addr", dm_addr_o, m_e.addr);
               chk("dm_wd", dm_wd_o, m_e.wd);
            end
         end
         if (done_o) begin
            take(2, m_ok, m_e);
            if (m_ok) begin
               chk("retire_pc", pc_o, m_e.pc);
               chk("latency", cyc, m_e.lat);
               chk("illegal", illegal_o, m_e.ill);
               chk("dm_re_seen", seen_re, m_e.dmre);
               chk("sreg_at_retire", sreg_o, m_e.sreg);
            end
            cyc = 0;
            seen_re = 1'b0;
         end else if (illegal_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL illegal_without_done: got illegal_o=1 expected 0");
         end
      end
   end

   // Instruction encoders.
   function automatic logic [15:0] enc_ldi(input logic [2:0] rc, input logic [6:0] imm);
      return {6'b010001, imm, rc};
   endfunction
   function automatic logic [15:0] enc_alu(input logic [3:0] fsl, input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rc);
      return {2'b00, fsl, ra, rb, rc, 1'b0};
   endfunction
   function automatic logic [15:0] enc_mov(input logic [2:0] rc, input logic [2:0] ra);
      return {6'b010010, rc, ra, 4'b0000};
   endfunction
   function automatic logic [15:0] enc_ld(input logic [2:0] rc, input logic [2:0] rb);
      return {6'b010100, rb, rc, 4'b0000};
   endfunction
   function automatic logic [15:0] enc_st(input logic [2:0] rb, input logic [2:0] ra);
      return {6'b011000, rb, ra, 4'b0000};
   endfunction
   function automatic logic [15:0] enc_br(input logic [3:0] cond, input logic [7:0] tgt);
      return {2'b10, cond, 2'b00, tgt};
   endfunction

   localparam logic [15:0] I_NOP  = 16'hC000;
   localparam logic [15:0] I_HALT = 16'hC400;
   localparam logic [15:0] I_BAD  = 16'hFC00;

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = I_NOP;
   endtask

   task automatic preload(input logic [2:0] a, input logic [7:0] d);
      pre_a = a; pre_d = d; pre_we = 1'b1;
      @(posedge clk); #2;
      pre_we = 1'b0;
   endtask

   task automatic wait_drain(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (sbq.size() == 0) break;
      end
      chk(name, sbq.size(), 0);
      if (sbq.size() != 0) sbq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear_imem();
      @(posedge clk); #2;
      chk("rst_pc", pc_o, 8'h00);
      chk("rst_sreg", sreg_o, 4'h0);
      chk("rst_halted", halted_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_illegal", illegal_o, 1'b0);
      chk("rst_rf_we", rf_we_o, 1'b0);
      chk("rst_dm_we", dm_we_o, 1'b0);
      chk("rst_dm_re", dm_re_o, 1'b0);

      // LDI, ALU add with carry/zero, branches, MOV, illegal encodings, HALT.
      imem[8'h00] = enc_ldi(3'd3, 7'h55);
      imem[8'h01] = enc_alu(4'd0, 3'd1, 3'd2, 3'd4);
      imem[8'h02] = enc_br(4'd1, 8'h40);
      imem[8'h40] = enc_br(4'd4, 8'h10);
      imem[8'h41] = enc_mov(3'd5, 3'd3);
      imem[8'h42] = I_BAD;
      imem[8'h43] = enc_br(4'd7, 8'h00);
      imem[8'h44] = enc_br(4'd0, 8'h50);
      imem[8'h50] = I_HALT;
      for (int i = 0; i < 8; i++) preload(i[2:0], 8'h00);
      preload(3'd1, 8'hFF);
      preload(3'd2, 8'h01);
      e_rfw(3'd3, 8'h55, 8'h00, 1'b0); e_ret(8'h00, 3, 1'b0, 1'b0, 4'h0);
      e_rfw(3'd4, 8'h00, 8'h01, 1'b1); e_ret(8'h01, 4, 1'b0, 1'b0, 4'h0);
      e_ret(8'h02, 2, 1'b0, 1'b0, 4'h3);
      e_ret(8'h40, 2, 1'b0, 1'b0, 4'h3);
      e_rfw(3'd5, 8'h55, 8'h00, 1'b0); e_ret(8'h41, 4, 1'b0, 1'b0, 4'h3);
      e_ret(8'h42, 2, 1'b1, 1'b0, 4'h3);
      e_ret(8'h43, 2, 1'b1, 1'b0, 4'h3);
      e_ret(8'h44, 2, 1'b0, 1'b0, 4'h3);
      e_ret(8'h50, 2, 1'b0, 1'b0, 4'h3);
      rst = 1'b0;
      wait_drain(200, "drain_prog_a");
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         chk("halted", halted_o, 1'b1);
         chk("halt_pc", pc_o, 8'h50);
      end
      rst = 1'b1;
      @(posedge clk); #2;
      chk("halt_cleared", halted_o, 1'b0);
      chk("halt_rst_pc", pc_o, 8'h00);

      // ST/LD round trip, ALU without flags, Z-clear branches, PC wrap.
      clear_imem();
      imem[8'h00] = enc_st(3'd2, 3'd4);
      imem[8'h01] = enc_ld(3'd6, 3'd2);
      imem[8'h02] = enc_alu(4'd0, 3'd1, 3'd3, 3'd7);
      imem[8'h03] = enc_br(4'd1, 8'h40);
      imem[8'h04] = enc_br(4'd2, 8'hFF);
      imem[8'hFF] = I_NOP;
      preload(3'd1, 8'h10);
      preload(3'd2, 8'h05);
      preload(3'd3, 8'h10);
      preload(3'd4, 8'hA7);
      e_dmw(3'd5, 8'hA7);               e_ret(8'h00, 4, 1'b0, 1'b0, 4'h0);
      e_rfw(3'd6, 8'hA7, 8'h00, 1'b0); e_ret(8'h01, 5, 1'b0, 1'b1, 4'h0);
      e_rfw(3'd7, 8'h20, 8'h00, 1'b1); e_ret(8'h02, 4, 1'b0, 1'b0, 4'h0);
      e_ret(8'h03, 2, 1'b0, 1'b0, 4'h0);
      e_ret(8'h04, 2, 1'b0, 1'b0, 4'h0);
      e_ret(8'hFF, 2, 1'b0, 1'b0, 4'h0);
      rst = 1'b0;
      wait_drain(200, "drain_prog_b");
      chk("wrap_pc", pc_o, 8'h00);
      rst = 1'b1;
      @(posedge clk); #2;

      // Reset during the WB cycle of the second ALU op aborts its write.
      clear_imem();
      imem[8'h00] = enc_alu(4'd0, 3'd1, 3'd2, 3'd4);
      imem[8'h01] = enc_alu(4'd0, 3'd1, 3'd2, 3'd5);
      preload(3'd1, 8'hFF);
      preload(3'd2, 8'h01);
      preload(3'd4, 8'h77);
      preload(3'd5, 8'h77);
      e_rfw(3'd4, 8'h00, 8'h01, 1'b1); e_ret(8'h00, 4, 1'b0, 1'b0, 4'h0);
      rst = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      chk("pre_abort_pc", pc_o, 8'h01);
      chk("pre_abort_sreg", sreg_o, 4'h3);
      rst = 1'b1;
      @(posedge clk); #2;
      chk("abort_pc", pc_o, 8'h00);
      chk("abort_sreg", sreg_o, 4'h0);
      chk("abort_rf5", rf[5], 8'h77);
      chk("abort_rf4", rf[4], 8'h00);
      chk("abort_queue", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
